// File: rtl/sc_rstk_pkg.sv
// Shared types for the return-address stack: FSM states and the push/pop op decode.
package sc_rstk_pkg;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_PARTIAL,
    S_FULL
  } rstk_state_t;

  // Encoded as {push, pop} so the request pins cast straight to an op.
  typedef enum logic [1:0] {
    NOP     = 2'b00,
    POP     = 2'b01,
    PUSH    = 2'b10,
    REPLACE = 2'b11
  } rstk_op_t;

endpackage

// File: rtl/sc_rstk_mem.sv
// Return-stack storage: one synchronous write port, one asynchronous read port, no reset.
module sc_rstk_mem #(
  parameter int DATAWIDTH = 11,
  parameter int DEPTH     = 8,
  parameter int PTRWIDTH  = 3
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [PTRWIDTH-1:0]  waddr,
  input  logic [DATAWIDTH-1:0] wdata,
  input  logic [PTRWIDTH-1:0]  raddr,
  output logic [DATAWIDTH-1:0] rdata
);

  logic [DATAWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sc_return_addr_stack.sv
// Hardware return-address stack: push captures PC+1 on a call, pop returns it on a return.
module sc_return_addr_stack
  import sc_rstk_pkg::*;
#(
  parameter int DATAWIDTH_BUS_RSTK = 11,
  parameter int DEPTH_RSTK         = 8,
  parameter int PTRWIDTH_RSTK      = 3
) (
  input  logic                          SC_CSAI_CLOCK_50,
  input  logic                          SC_CSAI_RESET_InHigh,
  input  logic                          RSTK_CLEAR_InHigh,
  input  logic                          RSTK_PUSH_InHigh,
  input  logic                          RSTK_POP_InHigh,
  input  logic [DATAWIDTH_BUS_RSTK-1:0] RSTK_DATA_INPUT,
  output logic [DATAWIDTH_BUS_RSTK-1:0] RSTK_DATA_OUTPUT,
  output logic                          RSTK_VALID_OutHigh,
  output logic                          RSTK_EMPTY_OutHigh,
  output logic                          RSTK_FULL_OutHigh,
  output logic [PTRWIDTH_RSTK:0]        RSTK_COUNT,
  output logic                          RSTK_OVERFLOW_OutHigh,
  output logic                          RSTK_UNDERFLOW_OutHigh
);

  localparam logic [PTRWIDTH_RSTK:0] FULL_COUNT = (PTRWIDTH_RSTK+1)'(DEPTH_RSTK);

  rstk_state_t                   state, state_next;
  rstk_op_t                      op;
  logic [PTRWIDTH_RSTK:0]        count, count_next;
  logic [DATAWIDTH_BUS_RSTK-1:0] data_out, data_out_next;
  logic                          valid, valid_next;
  logic                          overflow, overflow_next;
  logic                          underflow, underflow_next;

  logic                          mem_we;
  logic [PTRWIDTH_RSTK-1:0]      mem_waddr;
  logic [PTRWIDTH_RSTK-1:0]      top_idx;
  logic [DATAWIDTH_BUS_RSTK-1:0] mem_rdata;

  assign op      = rstk_op_t'({RSTK_PUSH_InHigh, RSTK_POP_InHigh});
  // Wraps to DEPTH-1 when full, which is exactly the top slot.
  assign top_idx = count[PTRWIDTH_RSTK-1:0] - 1'b1;

  sc_rstk_mem #(
    .DATAWIDTH (DATAWIDTH_BUS_RSTK),
    .DEPTH     (DEPTH_RSTK),
    .PTRWIDTH  (PTRWIDTH_RSTK)
  ) u_mem (
    .clk   (SC_CSAI_CLOCK_50),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (RSTK_DATA_INPUT),
    .raddr (top_idx),
    .rdata (mem_rdata)
  );

  always_ff @(posedge SC_CSAI_CLOCK_50 or posedge SC_CSAI_RESET_InHigh) begin
    if (SC_CSAI_RESET_InHigh) begin
      state     <= S_EMPTY;
      count     <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      data_out  <= data_out_next;
      valid     <= valid_next;
      overflow  <= overflow_next;
      underflow <= underflow_next;
    end
  end

  always_comb begin
    count_next     = count;
    data_out_next  = data_out;
    valid_next     = 1'b0;
    overflow_next  = overflow;
    underflow_next = underflow;
    mem_we         = 1'b0;
    mem_waddr      = count[PTRWIDTH_RSTK-1:0];
    state_next     = state;

    if (RSTK_CLEAR_InHigh) begin
      count_next     = '0;
      data_out_next  = '0;
      overflow_next  = 1'b0;
      underflow_next = 1'b0;
    end else begin
      unique case (op)
        PUSH: begin
          if (state == S_FULL) begin
            overflow_next = 1'b1;
          end else begin
            mem_we     = 1'b1;
            count_next = count + 1'b1;
          end
        end
        POP: begin
          if (state == S_EMPTY) begin
            underflow_next = 1'b1;
          end else begin
            data_out_next = mem_rdata;
            valid_next    = 1'b1;
            count_next    = count - 1'b1;
          end
        end
        REPLACE: begin
          valid_next = 1'b1;
          // Empty stack forwards the incoming address straight through.
          if (state == S_EMPTY) begin
            data_out_next = RSTK_DATA_INPUT;
          end else begin
            data_out_next = mem_rdata;
            mem_we        = 1'b1;
            mem_waddr     = top_idx;
          end
        end
        default: ;
      endcase
    end

    if (count_next == '0)             state_next = S_EMPTY;
    else if (count_next == FULL_COUNT) state_next = S_FULL;
    else                               state_next = S_PARTIAL;
  end

  assign RSTK_DATA_OUTPUT       = data_out;
  assign RSTK_VALID_OutHigh     = valid;
  assign RSTK_EMPTY_OutHigh     = (state == S_EMPTY);
  assign RSTK_FULL_OutHigh      = (state == S_FULL);
  assign RSTK_COUNT             = count;
  assign RSTK_OVERFLOW_OutHigh  = overflow;
  assign RSTK_UNDERFLOW_OutHigh = underflow;

endmodule
